// File: rtl/acc_core_pkg.sv
// rtl/acc_core_pkg.sv - shared types and constants for the acc_core processor
//
// Purpose: opcode and FSM state enumerations plus instruction field positions
//          used by acc_core and acc_regfile.
// Ports:   none (package).
package acc_core_pkg;

    localparam int INSTR_W   = 16;

    // Instruction word layout: [15:12] opcode, [11:8] register index, [7:0] imm8
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int REG_MSB   = 11;
    localparam int REG_LSB   = 8;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    localparam int REG_IDX_W = REG_MSB - REG_LSB + 1;
    localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOVR = 4'h2,
        OP_MOVA = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_INC  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_JPZ  = 4'hA,
        OP_JPNZ = 4'hB,
        OP_TX   = 4'hC,
        OP_MUL  = 4'hD,
        OP_RSVD = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/acc_regfile.sv
// rtl/acc_regfile.sv - general register file for acc_core
//
// Purpose: NREGS x DATA_W registers, one combinational read port and one
//          synchronous write port. Indices >= NREGS read as zero and are
//          never written.
// Ports:   clock, reset (async, active-high)
//          rd_idx  -> rd_data   combinational read
//          wr_en, wr_idx, wr_data   write on rising clock edge
module acc_regfile
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]    wr_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Decoding by comparison keeps out-of-range indices from aliasing onto
    // existing registers: no entry matches, so reads give 0 and writes drop.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_idx == REG_IDX_W'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_idx == REG_IDX_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: rtl/acc_core.sv
// rtl/acc_core.sv - multicycle accumulator processor core
//
// Purpose: FETCH/LOAD/EXEC/MEM/HALT core executing 16-bit instructions from
//          IRAM against an accumulator, register file and zero flag, with a
//          req/ack DRAM port of variable latency.
// Ports:   clock, reset (async, active-high)
//          IRAM_address / IRAM_data         instruction fetch (data one cycle late)
//          DRAM_address, DRAM_output_data, write_DRAM, dram_req  registered
//          DRAM_input_data, dram_ack        load data / completion
//          start_Tx                         one-cycle pulse from TX
//          halted                           high in HALT
// Build:   define ACC_CORE_MUL_EN to enable the opcode D multiplier;
//          otherwise opcode D is a NOP.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 16,
    parameter int NREGS   = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IADDR_W-1:0] IRAM_address,
    input  logic [INSTR_W-1:0] IRAM_data,
    output logic [DADDR_W-1:0] DRAM_address,
    output logic [DATA_W-1:0]  DRAM_output_data,
    input  logic [DATA_W-1:0]  DRAM_input_data,
    output logic               dram_req,
    output logic               write_DRAM,
    input  logic               dram_ack,
    output logic               start_Tx,
    output logic               halted
);

    state_e               state_q, state_d;
    logic [IADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    ac_q, ac_d;
    logic                 z_q, z_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic                 tx_q, tx_d;
    logic [DADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]    dout_q, dout_d;

    opcode_e              opcode;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [IMM_W-1:0]     imm8;
    logic [DATA_W-1:0]    rd_data;
    logic                 rf_we;
    logic                 upd_z;
    logic                 mem_done;

    assign opcode  = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
    assign reg_idx = ir_q[REG_MSB:REG_LSB];
    assign imm8    = ir_q[IMM_MSB:IMM_LSB];

    // dram_ack only counts while a request is outstanding
    assign mem_done = dram_ack && req_q;

    acc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .rd_idx  (reg_idx),
        .rd_data (rd_data),
        .wr_en   (rf_we),
        .wr_idx  (reg_idx),
        .wr_data (ac_q)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            ac_q    <= '0;
            z_q     <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            tx_q    <= 1'b0;
            daddr_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            z_q     <= z_d;
            req_q   <= req_d;
            we_q    <= we_d;
            tx_q    <= tx_d;
            daddr_q <= daddr_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OP_LD, OP_ST: state_d = ST_MEM;
                    OP_HALT:      state_d = ST_HALT;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM:   state_d = mem_done ? ST_FETCH : ST_MEM;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        z_d     = z_q;
        req_d   = req_q;
        we_d    = we_q;
        tx_d    = 1'b0;
        daddr_d = daddr_q;
        dout_d  = dout_q;
        rf_we   = 1'b0;
        upd_z   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                ir_d = IRAM_data;
                pc_d = pc_q + IADDR_W'(1);
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        ac_d  = DATA_W'(imm8);
                        upd_z = 1'b1;
                    end
                    OP_MOVR: rf_we = 1'b1;
                    OP_MOVA: begin
                        ac_d  = rd_data;
                        upd_z = 1'b1;
                    end
                    OP_ADD: begin
                        ac_d  = ac_q + rd_data;
                        upd_z = 1'b1;
                    end
                    OP_SUB: begin
                        ac_d  = ac_q - rd_data;
                        upd_z = 1'b1;
                    end
                    OP_INC: begin
                        ac_d  = ac_q + DATA_W'(1);
                        upd_z = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        daddr_d = DADDR_W'(rd_data);
                        dout_d  = ac_q;
                        we_d    = (opcode == OP_ST);
                        req_d   = 1'b1;
                    end
                    OP_JMP: pc_d = IADDR_W'(imm8);
                    OP_JPZ: begin
                        if (z_q) begin
                            pc_d = IADDR_W'(imm8);
                        end
                    end
                    OP_JPNZ: begin
                        if (!z_q) begin
                            pc_d = IADDR_W'(imm8);
                        end
                    end
                    OP_TX: tx_d = 1'b1;
`ifdef ACC_CORE_MUL_EN
                    OP_MUL: begin
                        ac_d  = ac_q * rd_data;
                        upd_z = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (mem_done) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        ac_d  = DRAM_input_data;
                        upd_z = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (upd_z) begin
            z_d = (ac_d == '0);
        end
    end

    assign IRAM_address     = pc_q;
    assign DRAM_address     = daddr_q;
    assign DRAM_output_data = dout_q;
    assign dram_req         = req_q;
    assign write_DRAM       = we_q;
    assign start_Tx         = tx_q;
    assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - self-checking bench for acc_core
module tb_acc_core;

    localparam logic [3:0] LDI = 4'h1, MOVR = 4'h2, MOVA = 4'h3, ADD = 4'h4,
                           SUB = 4'h5, INC = 4'h6, LD = 4'h7, ST = 4'h8,
                           JPZ = 4'hA, JPNZ = 4'hB, TX = 4'hC, MUL = 4'hD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  IRAM_address;
    logic [15:0] IRAM_data = 16'h0;
    logic [15:0] DRAM_address;
    logic [15:0] DRAM_output_data;
    logic [15:0] DRAM_input_data = 16'h0;
    logic        dram_req;
    logic        write_DRAM;
    logic        dram_ack = 1'b0;
    logic        start_Tx;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] imem [256];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int          delay;
    } txn_t;
    txn_t sb[$];

    acc_core dut (
        .clock            (clock),
        .reset            (reset),
        .IRAM_address     (IRAM_address),
        .IRAM_data        (IRAM_data),
        .DRAM_address     (DRAM_address),
        .DRAM_output_data (DRAM_output_data),
        .DRAM_input_data  (DRAM_input_data),
        .dram_req         (dram_req),
        .write_DRAM       (write_DRAM),
        .dram_ack         (dram_ack),
        .start_Tx         (start_Tx),
        .halted           (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) IRAM_data <= imem[IRAM_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r, input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic push(input logic we, input logic [15:0] addr, input logic [15:0] data, input int delay);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.delay = delay;
        sb.push_back(t);
    endtask

    // Returns at the negedge on which reset was released
    task automatic start();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // DRAM responder: pops the expected transaction when a request opens,
    // acks after the entry's delay, and checks request duration on close.
    bit          in_txn = 1'b0;
    int          hold = 0;
    txn_t        cur;
    logic [15:0] txn_addr;
    logic        txn_we;

    always @(negedge clock) begin
        if (reset) begin
            in_txn   = 1'b0;
            hold     = 0;
            dram_ack = 1'b0;
        end else if (dram_req) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                hold   = 0;
                if (sb.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                    cur.we = 1'b0; cur.addr = '0; cur.data = '0; cur.delay = 0;
                end else begin
                    cur = sb.pop_front();
                end
                check("dram_we", 32'(write_DRAM), 32'(cur.we));
                check("dram_addr", 32'(DRAM_address), 32'(cur.addr));
                if (cur.we) check("st_data", 32'(DRAM_output_data), 32'(cur.data));
                txn_addr = DRAM_address;
                txn_we   = write_DRAM;
            end else begin
                check("addr_stable", 32'(DRAM_address), 32'(txn_addr));
                check("we_stable", 32'(write_DRAM), 32'(txn_we));
            end
            hold++;
            if (hold == cur.delay + 1) begin
                dram_ack        = 1'b1;
                DRAM_input_data = cur.data;
            end else begin
                dram_ack        = 1'b0;
                DRAM_input_data = 16'hDEAD;
            end
        end else begin
            if (in_txn) begin
                check("req_cycles", 32'(hold), 32'(cur.delay + 1));
                in_txn = 1'b0;
            end
            dram_ack = 1'b0;
        end
    end

    initial begin
        int cyc;
        clear_prog();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req", 32'(dram_req), 32'd0);
        check("rst_we", 32'(write_DRAM), 32'd0);
        check("rst_tx", 32'(start_Tx), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_daddr", 32'(DRAM_address), 32'd0);
        check("rst_dout", 32'(DRAM_output_data), 32'd0);
        check("rst_iaddr", 32'(IRAM_address), 32'd0);

        // Halt timing: 5 non-memory instructions
        clear_prog();
        imem[0] = ins(LDI, 0, 8'd5);
        imem[1] = ins(MOVR, 1, 0);
        imem[2] = ins(LDI, 0, 8'd3);
        imem[3] = ins(SUB, 1, 0);
        start();
        wait_halt("t1", 100, cyc);
        check("t1_halt_cycles", 32'(cyc), 32'd15);

        // SUB wrap, JPNZ taken, INC wrap to zero, JPZ taken, ADD
        clear_prog();
        imem[8'h00] = ins(LDI, 0, 8'h80);
        imem[8'h01] = ins(MOVR, 0, 0);
        imem[8'h02] = ins(LDI, 0, 8'd5);
        imem[8'h03] = ins(MOVR, 1, 0);
        imem[8'h04] = ins(LDI, 0, 8'd3);
        imem[8'h05] = ins(SUB, 1, 0);
        imem[8'h06] = ins(ST, 0, 0);
        imem[8'h07] = ins(JPNZ, 0, 8'h20);
        imem[8'h20] = ins(INC, 0, 0);
        imem[8'h21] = ins(ST, 0, 0);
        imem[8'h22] = ins(INC, 0, 0);
        imem[8'h23] = ins(JPZ, 0, 8'h28);
        imem[8'h28] = ins(ADD, 1, 0);
        imem[8'h29] = ins(ST, 0, 0);
        push(1'b1, 16'h0080, 16'hFFFE, 0);
        push(1'b1, 16'h0080, 16'hFFFF, 1);
        push(1'b1, 16'h0080, 16'h0005, 3);
        start();
        wait_halt("t1b", 300, cyc);

        // Branch fetch address: JPZ taken, JPZ not taken, JPNZ taken
        clear_prog();
        imem[8'h00] = ins(LDI, 0, 8'd0);
        imem[8'h01] = ins(JPZ, 0, 8'h10);
        imem[8'h10] = ins(LDI, 0, 8'd1);
        imem[8'h11] = ins(JPZ, 0, 8'h00);
        imem[8'h12] = ins(JPNZ, 0, 8'h30);
        start();
        repeat (6) @(negedge clock);
        check("t2_jpz_taken", 32'(IRAM_address), 32'h10);
        repeat (6) @(negedge clock);
        check("t2_jpz_fall", 32'(IRAM_address), 32'h12);
        repeat (3) @(negedge clock);
        check("t2_jpnz_taken", 32'(IRAM_address), 32'h30);
        wait_halt("t2", 100, cyc);

        // LD with 4 wait cycles, then store the loaded value
        clear_prog();
        imem[0] = ins(LDI, 0, 8'h40);
        imem[1] = ins(MOVR, 3, 0);
        imem[2] = ins(LD, 3, 0);
        imem[3] = ins(JPZ, 0, 8'h20);
        imem[4] = ins(ST, 3, 0);
        push(1'b0, 16'h0040, 16'h00AB, 4);
        push(1'b1, 16'h0040, 16'h00AB, 0);
        start();
        wait_halt("t3", 200, cyc);
        check("t3_cycles", 32'(cyc), 32'd24);

        // ST of AC=1234 to R0=0040
        clear_prog();
        imem[0] = ins(LDI, 0, 8'h40);
        imem[1] = ins(MOVR, 0, 0);
        imem[2] = ins(LDI, 0, 8'h60);
        imem[3] = ins(MOVR, 1, 0);
        imem[4] = ins(LD, 1, 0);
        imem[5] = ins(ST, 0, 0);
        push(1'b0, 16'h0060, 16'h1234, 1);
        push(1'b1, 16'h0040, 16'h1234, 2);
        start();
        wait_halt("t4", 200, cyc);

        // Out-of-range register index
        clear_prog();
        imem[8'h00] = ins(LDI, 0, 8'h40);
        imem[8'h01] = ins(MOVR, 0, 0);
        imem[8'h02] = ins(LDI, 0, 8'h33);
        imem[8'h03] = ins(MOVR, 9, 0);
        imem[8'h04] = ins(MOVA, 9, 0);
        imem[8'h05] = ins(JPZ, 0, 8'h20);
        imem[8'h20] = ins(ST, 0, 0);
        imem[8'h21] = ins(MOVA, 1, 0);
        imem[8'h22] = ins(ST, 0, 0);
        push(1'b1, 16'h0040, 16'h0000, 0);
        push(1'b1, 16'h0040, 16'h0000, 0);
        start();
        wait_halt("t6", 200, cyc);

        // TX pulse timing
        clear_prog();
        imem[0] = ins(TX, 0, 0);
        start();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            check($sformatf("tx_cycle%0d", i), 32'(start_Tx), 32'(i == 3));
        end
        wait_halt("tx", 50, cyc);

        // MUL (or NOP when the multiplier is not built)
        clear_prog();
        imem[8'h00] = ins(LDI, 0, 8'h40);
        imem[8'h01] = ins(MOVR, 0, 0);
        imem[8'h02] = ins(LDI, 0, 8'd6);
        imem[8'h03] = ins(MOVR, 2, 0);
        imem[8'h04] = ins(LDI, 0, 8'd7);
        imem[8'h05] = ins(MUL, 2, 0);
        imem[8'h06] = ins(ST, 0, 0);
        imem[8'h07] = ins(MUL, 3, 0);
        imem[8'h08] = ins(JPZ, 0, 8'h20);
        imem[8'h09] = ins(ST, 0, 0);
        imem[8'h20] = ins(INC, 0, 0);
        imem[8'h21] = ins(ST, 0, 0);
`ifdef ACC_CORE_MUL_EN
        push(1'b1, 16'h0040, 16'd42, 0);
        push(1'b1, 16'h0040, 16'd1, 0);
`else
        push(1'b1, 16'h0040, 16'd7, 0);
        push(1'b1, 16'h0040, 16'd7, 0);
`endif
        start();
        wait_halt("t7", 300, cyc);

        // Reset during the second MEM cycle
        clear_prog();
        imem[0] = ins(LDI, 0, 8'h40);
        imem[1] = ins(MOVR, 0, 0);
        imem[2] = ins(LD, 0, 0);
        push(1'b0, 16'h0040, 16'h0099, 10);
        start();
        repeat (10) @(negedge clock);
        check("t5_req_before", 32'(dram_req), 32'd1);
        clear_prog();
        reset = 1'b1;
        #1;
        check("t5_req_async", 32'(dram_req), 32'd0);
        check("t5_iaddr_rst", 32'(IRAM_address), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("t5_iaddr_restart", 32'(IRAM_address), 32'd0);
        wait_halt("t5", 50, cyc);
        check("t5_cycles", 32'(cyc), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
